// File: rtl/frame_readout.sv
// Streams a captured frame from a byte-wide buffer as RGB565 pixels over valid/ready.
// Two bytes per pixel at consecutive addresses, high byte first; one readout per start_read.
module frame_readout #(
  parameter int unsigned H_RES     = 160,
  parameter int unsigned TOTAL_ROW = 120,
  parameter int unsigned BUFF_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_read,
  input  logic                 frame_captured,
  output logic [BUFF_BITS-1:0] rd_addr,
  input  logic [7:0]           rd_data,
  output logic [15:0]          pix_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 line_end,
  output logic                 frame_end,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned Y_W = (TOTAL_ROW > 1) ? $clog2(TOTAL_ROW) : 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ_HI,
    CAP_HI,
    CAP_LO,
    SEND,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [BUFF_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]           hi_q, hi_d;
  logic [15:0]          pix_data_q, pix_data_d;
  logic                 pix_valid_q, pix_valid_d;
  logic                 line_end_q, line_end_d;
  logic                 frame_end_q, frame_end_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic                 last_x_c;
  logic                 last_y_c;

  assign last_x_c = (x_q == X_W'(H_RES - 1));
  assign last_y_c = (y_q == Y_W'(TOTAL_ROW - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      hi_q        <= '0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      hi_q        <= hi_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    hi_d        = hi_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = pix_valid_q;
    line_end_d  = line_end_q;
    frame_end_d = frame_end_q;
    busy_d      = busy_q;
    done_d      = done_q;
    x_d         = x_q;
    y_d         = y_q;

    unique case (state_q)
      IDLE: begin
        if (start_read && frame_captured) begin
          rd_addr_d = '0;
          x_d       = '0;
          y_d       = '0;
          busy_d    = 1'b1;
          state_d   = REQ_HI;
        end
      end
      REQ_HI: begin
        rd_addr_d = rd_addr_q + BUFF_BITS'(1);
        state_d   = CAP_HI;
      end
      CAP_HI: begin
        hi_d    = rd_data;
        state_d = CAP_LO;
      end
      CAP_LO: begin
        pix_data_d  = {hi_q, rd_data};
        pix_valid_d = 1'b1;
        line_end_d  = last_x_c;
        frame_end_d = last_x_c && last_y_c;
        state_d     = SEND;
      end
      SEND: begin
        if (pix_ready) begin
          pix_valid_d = 1'b0;
          line_end_d  = 1'b0;
          frame_end_d = 1'b0;
          if (frame_end_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            rd_addr_d = rd_addr_q + BUFF_BITS'(1);
            if (last_x_c) begin
              x_d = '0;
              y_d = y_q + Y_W'(1);
            end else begin
              x_d = x_q + X_W'(1);
            end
            state_d = REQ_HI;
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Dropping start_read leaves any active state, overriding a same-cycle accept
    if (state_q != IDLE && !start_read) begin
      state_d     = IDLE;
      pix_valid_d = 1'b0;
      line_end_d  = 1'b0;
      frame_end_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      rd_addr_d   = '0;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign line_end  = line_end_q;
  assign frame_end = frame_end_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_frame_readout.sv
// Directed bench for frame_readout on a reduced 80x4 frame; buffer model returns byte[n]=n[7:0].
module tb_frame_readout;

  localparam int unsigned H      = 80;
  localparam int unsigned R      = 4;
  localparam int unsigned NPIX   = H * R;
  localparam int unsigned NBYTES = NPIX * 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_read;
  logic        frame_captured;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data = 8'h00;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        line_end;
  logic        frame_end;
  logic        busy;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] max_addr = 16'h0000;

  frame_readout #(.H_RES(H), .TOTAL_ROW(R), .BUFF_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_read(start_read), .frame_captured(frame_captured),
    .rd_addr(rd_addr), .rd_data(rd_data), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .line_end(line_end), .frame_end(frame_end), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read buffer: data for rd_addr appears one cycle later
  always @(posedge clk) begin
    rd_data <= rd_addr[7:0];
    if (rd_addr > max_addr) max_addr <= rd_addr;
  end

  function automatic logic [15:0] exp_pix(input int p);
    logic [7:0] hi_b;
    logic [7:0] lo_b;
    hi_b = 8'(2 * p);
    lo_b = 8'(2 * p + 1);
    return {hi_b, lo_b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Consume pixels until frame_end is accepted, checking order, markers and stalls
  task automatic stream_frame(input bit rand_ready);
    int idx = 0;
    int cyc = 0;
    int last_acc = -1;
    int le_cnt = 0;
    int fe_cnt = 0;
    bit stalled = 0;
    bit just_acc = 0;
    bit fin = 0;
    logic [15:0] held = '0;
    while (!fin && cyc < 20000) begin
      if (just_acc) begin
        n_cmp++;
        if (rd_addr !== 16'(2 * idx)) begin
          n_fail++;
          $display("FAIL rd_addr_seq pix %0d: got %0d expected %0d", idx, rd_addr, 2 * idx);
        end
      end
      just_acc = 0;
      if (stalled) begin
        n_cmp++;
        if ({pix_valid, pix_data} !== {1'b1, held}) begin
          n_fail++;
          $display("FAIL stall_hold pix %0d: got %0b/%04h expected 1/%04h", idx, pix_valid, pix_data, held);
        end
      end
      stalled = 0;
      pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pix_valid && pix_ready) begin
        n_cmp++;
        if (pix_data !== exp_pix(idx)) begin
          n_fail++;
          $display("FAIL pix_data pix %0d: got %04h expected %04h", idx, pix_data, exp_pix(idx));
        end
        n_cmp++;
        if (line_end !== ((idx % H) == H - 1)) begin
          n_fail++;
          $display("FAIL line_end pix %0d: got %0b expected %0b", idx, line_end, (idx % H) == H - 1);
        end
        n_cmp++;
        if (frame_end !== (idx == NPIX - 1)) begin
          n_fail++;
          $display("FAIL frame_end pix %0d: got %0b expected %0b", idx, frame_end, idx == NPIX - 1);
        end
        if (!rand_ready && last_acc >= 0) begin
          n_cmp++;
          if (cyc - last_acc != 4) begin
            n_fail++;
            $display("FAIL pix_interval pix %0d: got %0d expected 4", idx, cyc - last_acc);
          end
        end
        le_cnt += int'(line_end);
        fe_cnt += int'(frame_end);
        last_acc = cyc;
        if (idx == NPIX - 1) fin = 1;
        else just_acc = 1;
        idx++;
      end else if (pix_valid) begin
        stalled = 1;
        held = pix_data;
      end
      step();
      cyc++;
    end
    pix_ready = 1'b1;
    n_cmp++;
    if (!fin || idx != NPIX) begin
      n_fail++;
      $display("FAIL frame_count: got %0d expected %0d", idx, NPIX);
    end
    n_cmp++;
    if (le_cnt != R || fe_cnt != 1) begin
      n_fail++;
      $display("FAIL marker_count: got line %0d frame %0d expected %0d / 1", le_cnt, fe_cnt, R);
    end
    n_cmp++;
    if ({done, busy, pix_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL done_state: got done/busy/valid %b expected 100", {done, busy, pix_valid});
    end
    n_cmp++;
    if (rd_addr !== 16'(NBYTES - 1)) begin
      n_fail++;
      $display("FAIL final_addr: got %0d expected %0d", rd_addr, NBYTES - 1);
    end
  endtask

  task automatic check_all_zero(input string name, input bit with_data);
    n_cmp++;
    if ({pix_valid, line_end, frame_end, busy, done} !== 5'b0 || rd_addr !== 16'h0 ||
        (with_data && pix_data !== 16'h0)) begin
      n_fail++;
      $display("FAIL %s: got v/le/fe/busy/done %b addr %0d data %04h expected all 0",
               name, {pix_valid, line_end, frame_end, busy, done}, rd_addr, pix_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_read = 1'b0; frame_captured = 1'b1; pix_ready = 1'b1;
    step(); step();
    check_all_zero("reset_state", 1'b1);
    rst_n = 1'b1; start_read = 1'b1;
    for (int i = 0; i < 30; i++) step();
    rst_n = 1'b0;
    step();
    check_all_zero("reset_mid_frame", 1'b1);
    rst_n = 1'b1; start_read = 1'b0;
    step();
  endtask

  task automatic test_full_frame();
    start_read = 1'b1; pix_ready = 1'b1;
    step(); step(); step();
    n_cmp++;
    if (pix_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL early_valid: got valid %0b busy %0b expected 0 1", pix_valid, busy);
    end
    step();
    n_cmp++;
    if (pix_valid !== 1'b1 || pix_data !== 16'h0001) begin
      n_fail++;
      $display("FAIL first_pixel: got %0b/%04h expected 1/0001", pix_valid, pix_data);
    end
    stream_frame(1'b0);
    step(); step(); step();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_hold: got done %0b busy %0b expected 1 0", done, busy);
    end
    start_read = 1'b0;
    step();
    n_cmp++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_clear: got %0b expected 0", done);
    end
  endtask

  task automatic test_stall();
    start_read = 1'b1;
    stream_frame(1'b1);
    start_read = 1'b0;
    step();
    check_all_zero("stall_rearm", 1'b0);
  endtask

  task automatic test_no_frame();
    frame_captured = 1'b0; start_read = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if ({busy, pix_valid} !== 2'b00 || rd_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL no_frame_idle: got busy %0b valid %0b addr %0d expected 0 0 0", busy, pix_valid, rd_addr);
    end
    frame_captured = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_on_captured: got busy %0b expected 1", busy);
    end
    frame_captured = 1'b0;
    step(); step(); step();
    n_cmp++;
    if (pix_valid !== 1'b1 || pix_data !== 16'h0001) begin
      n_fail++;
      $display("FAIL captured_ignored: got %0b/%04h expected 1/0001", pix_valid, pix_data);
    end
    frame_captured = 1'b1; start_read = 1'b0;
    step();
  endtask

  task automatic test_abort();
    int idx = 0;
    int cyc = 0;
    bit hit = 0;
    start_read = 1'b1; pix_ready = 1'b1;
    while (!hit && cyc < 5000) begin
      if (pix_valid && idx == 200) begin
        hit = 1;
        n_cmp++;
        if (pix_data !== exp_pix(200)) begin
          n_fail++;
          $display("FAIL abort_pix200: got %04h expected %04h", pix_data, exp_pix(200));
        end
        start_read = 1'b0;
      end else if (pix_valid) begin
        idx++;
      end
      step();
      cyc++;
    end
    n_cmp++;
    if (!hit) begin
      n_fail++;
      $display("FAIL abort_reach: got pixel %0d expected 200", idx);
    end
    check_all_zero("abort_state", 1'b0);
    start_read = 1'b1;
    step(); step(); step(); step();
    n_cmp++;
    if (pix_valid !== 1'b1 || pix_data !== 16'h0001) begin
      n_fail++;
      $display("FAIL restart_pixel0: got %0b/%04h expected 1/0001", pix_valid, pix_data);
    end
    start_read = 1'b0;
    step();
  endtask

  task automatic test_addr_bound();
    n_cmp++;
    if (max_addr !== 16'(NBYTES - 1)) begin
      n_fail++;
      $display("FAIL addr_bound: got max %0d expected %0d", max_addr, NBYTES - 1);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_read = 1'b0; frame_captured = 1'b0; pix_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_stall();
    test_no_frame();
    test_abort();
    test_addr_bound();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
